// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: core writeback has priority, memory load returns
// queue in a small FIFO, are drained into idle cycles, and are forwarded to the read ports.
module rf_write_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_we,
  input  logic [4:0]  core_rd,
  input  logic [31:0] core_wdata,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2,
  output logic        core_stall,
  output logic        busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic [SW-1:0]    starve_q, starve_d;

  logic active, nonempty, head_v, cw, push, pop;

  assign active     = ~reset;
  assign nonempty   = (count_q != '0);
  assign head_v     = vld_q[rptr_q];
  assign core_stall = active & (starve_q == SW'(STARVE_MAX));
  assign cw         = active & core_we & ~core_stall & (core_rd != 5'd0);
  assign mem_ready  = active & (count_q != CW'(DEPTH));
  assign push       = mem_valid & mem_ready & (mem_rd != 5'd0);
  assign pop        = active & ~cw & nonempty;
  assign busy       = active & nonempty;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (cw) begin
      rf_we    = 1'b1;
      rf_waddr = core_rd;
      rf_wdata = core_wdata;
    end else if (pop && head_v) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q[rptr_q];
      rf_wdata = data_q[rptr_q];
    end
  end

  // A valid bit only ever marks an occupied slot, so scanning oldest to youngest
  // and letting later matches override yields the youngest pending write.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = 32'd0;
    fwd_data2 = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr_q + PW'(i);
      if (active && vld_q[idx] && rd_addr1 != 5'd0 && rd_q[idx] == rd_addr1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = data_q[idx];
      end
      if (active && vld_q[idx] && rd_addr2 != 5'd0 && rd_q[idx] == rd_addr2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = data_q[idx];
      end
    end
  end

  // The core write is younger than anything already stored; the slot being
  // filled this cycle is set after the kill so a same-cycle return survives.
  always_comb begin
    vld_d = vld_q;
    if (cw) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_q[i] == core_rd) vld_d[i] = 1'b0;
      end
    end
    if (pop)  vld_d[rptr_q] = 1'b0;
    if (push) vld_d[wptr_q] = 1'b1;
  end

  always_comb begin
    starve_d = starve_q;
    if (!nonempty || pop) starve_d = '0;
    else if (head_v && cw && starve_q != SW'(STARVE_MAX)) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      vld_q    <= vld_d;
      starve_q <= starve_d;
      if (push) begin
        rd_q[wptr_q]   <= mem_rd;
        data_q[wptr_q] <= mem_wdata;
        wptr_q         <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_rf_write_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_we;
  logic [4:0]  core_rd;
  logic [31:0] core_wdata;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic        core_stall;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .core_we(core_we), .core_rd(core_rd), .core_wdata(core_wdata),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .core_stall(core_stall), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
    bit          v;
  } ent_t;

  ent_t q[$];
  int   starve = 0;

  // Reference model: evaluated at the falling edge with the current inputs,
  // then advanced to the state the rising edge will produce.
  always @(negedge clk) begin : model
    bit          e_stall, e_cw, e_ready, e_we, e_h1, e_h2, popped, head_was_v, was_empty;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_f1, e_f2;
    ent_t        ne;
    if (reset) begin
      chk("rst_mem_ready", 32'(mem_ready), 32'd0);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_fwd_hit1", 32'(fwd_hit1), 32'd0);
      chk("rst_fwd_hit2", 32'(fwd_hit2), 32'd0);
      chk("rst_core_stall", 32'(core_stall), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      q.delete();
      starve = 0;
    end else begin
      e_stall = (starve == STARVE_MAX);
      e_cw    = core_we && !e_stall && (core_rd != 5'd0);
      e_ready = (q.size() != DEPTH);
      e_h1 = 1'b0; e_f1 = 32'd0; e_h2 = 1'b0; e_f2 = 32'd0;
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (!e_h1 && q[k].v && rd_addr1 != 5'd0 && q[k].rd == rd_addr1) begin
          e_h1 = 1'b1; e_f1 = q[k].d;
        end
        if (!e_h2 && q[k].v && rd_addr2 != 5'd0 && q[k].rd == rd_addr2) begin
          e_h2 = 1'b1; e_f2 = q[k].d;
        end
      end
      was_empty  = (q.size() == 0);
      head_was_v = !was_empty && q[0].v;
      popped     = !e_cw && !was_empty;
      e_we = 1'b0; e_wa = 5'd0; e_wd = 32'd0;
      if (e_cw) begin
        e_we = 1'b1; e_wa = core_rd; e_wd = core_wdata;
      end else if (popped && head_was_v) begin
        e_we = 1'b1; e_wa = q[0].rd; e_wd = q[0].d;
      end
      chk("mem_ready", 32'(mem_ready), 32'(e_ready));
      chk("rf_we", 32'(rf_we), 32'(e_we));
      chk("rf_waddr", 32'(rf_waddr), 32'(e_wa));
      chk("rf_wdata", rf_wdata, e_wd);
      chk("fwd_hit1", 32'(fwd_hit1), 32'(e_h1));
      chk("fwd_data1", fwd_data1, e_f1);
      chk("fwd_hit2", 32'(fwd_hit2), 32'(e_h2));
      chk("fwd_data2", fwd_data2, e_f2);
      chk("core_stall", 32'(core_stall), 32'(e_stall));
      chk("busy", 32'(busy), 32'(!was_empty));

      if (e_cw)
        foreach (q[k]) if (q[k].rd == core_rd) q[k].v = 1'b0;
      if (popped) void'(q.pop_front());
      if (mem_valid && e_ready && mem_rd != 5'd0) begin
        ne.rd = mem_rd; ne.d = mem_wdata; ne.v = 1'b1;
        q.push_back(ne);
      end
      if (was_empty || popped) starve = 0;
      else if (head_was_v && e_cw && starve < STARVE_MAX) starve++;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; core_we = 1'b0; core_rd = 5'd0; core_wdata = 32'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_wdata = 32'd0;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // basic drain
    mem_valid = 1'b1; mem_rd = 5'd5; mem_wdata = 32'hA5A5_0001;
    @(negedge clk); chk("lit_drain_ready", 32'(mem_ready), 32'd1);
    nxt(); mem_valid = 1'b0;
    @(negedge clk);
    chk("lit_drain_we", 32'(rf_we), 32'd1);
    chk("lit_drain_waddr", 32'(rf_waddr), 32'd5);
    chk("lit_drain_wdata", rf_wdata, 32'hA5A5_0001);
    nxt();
    @(negedge clk); chk("lit_drain_busy", 32'(busy), 32'd0);
    nxt();

    // priority, full, starvation stall
    core_we = 1'b1; core_rd = 5'd1; core_wdata = 32'h100;
    mem_valid = 1'b1; mem_rd = 5'd8; mem_wdata = 32'h80;
    nxt();
    mem_rd = 5'd9; mem_wdata = 32'h90; core_wdata = 32'h101;
    @(negedge clk);
    chk("lit_prio_waddr", 32'(rf_waddr), 32'd1);
    chk("lit_prio_ready", 32'(mem_ready), 32'd1);
    nxt(); mem_valid = 1'b0;
    @(negedge clk);
    chk("lit_full_ready", 32'(mem_ready), 32'd0);
    chk("lit_full_stall", 32'(core_stall), 32'd0);
    repeat (3) nxt();
    @(negedge clk);
    chk("lit_stall", 32'(core_stall), 32'd1);
    chk("lit_stall_we", 32'(rf_we), 32'd1);
    chk("lit_stall_waddr", 32'(rf_waddr), 32'd8);
    chk("lit_stall_wdata", rf_wdata, 32'h80);
    chk("lit_stall_ready", 32'(mem_ready), 32'd0);
    nxt(); core_we = 1'b0;
    @(negedge clk);
    chk("lit_after_ready", 32'(mem_ready), 32'd1);
    chk("lit_after_stall", 32'(core_stall), 32'd0);
    chk("lit_after_waddr", 32'(rf_waddr), 32'd9);
    nxt();
    @(negedge clk); chk("lit_prio_busy", 32'(busy), 32'd0);
    nxt();

    // WAW kill
    core_we = 1'b1; core_rd = 5'd2; core_wdata = 32'h5;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_wdata = 32'h1111; rd_addr1 = 5'd7;
    nxt(); mem_valid = 1'b0; core_rd = 5'd7; core_wdata = 32'h2222;
    @(negedge clk);
    chk("lit_waw_fwd", 32'(fwd_hit1), 32'd1);
    chk("lit_waw_fwdd", fwd_data1, 32'h1111);
    chk("lit_waw_waddr", 32'(rf_waddr), 32'd7);
    chk("lit_waw_wdata", rf_wdata, 32'h2222);
    nxt(); core_we = 1'b0;
    @(negedge clk);
    chk("lit_waw_killpop", 32'(rf_we), 32'd0);
    chk("lit_waw_fwd_off", 32'(fwd_hit1), 32'd0);
    chk("lit_waw_busy", 32'(busy), 32'd1);
    nxt();
    @(negedge clk); chk("lit_waw_empty", 32'(busy), 32'd0);
    rd_addr1 = 5'd0;
    nxt();

    // forwarding picks the youngest entry
    core_we = 1'b1; core_rd = 5'd1; core_wdata = 32'h33;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_wdata = 32'h10;
    nxt(); mem_wdata = 32'h20;
    nxt(); mem_valid = 1'b0; core_we = 1'b0; rd_addr2 = 5'd3;
    @(negedge clk);
    chk("lit_fwd_hit2", 32'(fwd_hit2), 32'd1);
    chk("lit_fwd_data2", fwd_data2, 32'h20);
    chk("lit_fwd_wdata0", rf_wdata, 32'h10);
    chk("lit_fwd_hit1_x0", 32'(fwd_hit1), 32'd0);
    nxt();
    @(negedge clk);
    chk("lit_fwd_hit2_b", 32'(fwd_hit2), 32'd1);
    chk("lit_fwd_data2_b", fwd_data2, 32'h20);
    chk("lit_fwd_wdata1", rf_wdata, 32'h20);
    nxt();
    @(negedge clk);
    chk("lit_fwd_hit2_off", 32'(fwd_hit2), 32'd0);
    chk("lit_fwd_data2_off", fwd_data2, 32'd0);
    rd_addr2 = 5'd0;
    nxt();

    // x0 handling
    core_we = 1'b1; core_rd = 5'd0; core_wdata = 32'hDEAD;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_wdata = 32'hBEEF;
    @(negedge clk);
    chk("lit_x0_we", 32'(rf_we), 32'd0);
    chk("lit_x0_ready", 32'(mem_ready), 32'd1);
    nxt(); core_we = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    chk("lit_x0_busy", 32'(busy), 32'd0);
    chk("lit_x0_we2", 32'(rf_we), 32'd0);
    nxt();

    // reset mid-operation
    core_we = 1'b1; core_rd = 5'd1; core_wdata = 32'h44;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_wdata = 32'hA;
    nxt(); mem_rd = 5'd11; mem_wdata = 32'hB;
    nxt(); mem_valid = 1'b0; core_we = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("lit_rst_we", 32'(rf_we), 32'd0);
    chk("lit_rst_ready", 32'(mem_ready), 32'd0);
    nxt(); reset = 1'b0;
    @(negedge clk);
    chk("lit_post_we", 32'(rf_we), 32'd0);
    chk("lit_post_busy", 32'(busy), 32'd0);
    chk("lit_post_stall", 32'(core_stall), 32'd0);
    chk("lit_post_ready", 32'(mem_ready), 32'd1);
    nxt();

    // mixed traffic, checked by the model only
    for (int i = 0; i < 60; i++) begin
      core_we    = (i % 3 != 0);
      core_rd    = 5'(i % 4);
      core_wdata = 32'(i) | 32'hC000_0000;
      mem_valid  = (i % 2 == 0);
      mem_rd     = 5'((i * 3) % 8);
      mem_wdata  = 32'(i) | 32'hE000_0000;
      rd_addr1   = 5'(i % 8);
      rd_addr2   = 5'((i + 3) % 8);
      nxt();
    end
    core_we = 1'b0; mem_valid = 1'b0;
    repeat (8) nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
